dmem_port_arbiter: RTL and testbench

Arbitration and sequencing controller that shares the single-ported 128-word data memory between the scalar load/store path and the 16-word vector load/store unit. Scalar accesses and vector loads complete in one cycle. The memory has one 32-bit write port, so the controller serializes each 512-bit vector store into 16 consecutive word writes and stalls the scalar port for the duration. It sits between the core's memory stage and the data memory; its `mem_*` ports connect directly to the memory's `a`, `wd`, `we`, `rd1` and `rd2` ports.

---
 rtl/dmem_port_arbiter_if.sv | 38 +++
 rtl/dmem_port_arbiter.sv | 134 +++++++++++++
 tb/tb_dmem_port_arbiter.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the scalar/vector requesters, the data memory and the arbiter.
// master: requesters plus memory read data; slave: the arbiter.
interface dmem_port_arbiter_if #(
  parameter int unsigned VLEN_WORDS = 16
);
  localparam int unsigned VW = 32 * VLEN_WORDS;

  logic          s_req;
  logic          s_we;
  logic [31:0]   s_addr;
  logic [31:0]   s_wdata;
  logic          s_gnt;
  logic [31:0]   s_rdata;

  logic          v_req;
  logic          v_we;
  logic [31:0]   v_addr;
  logic [VW-1:0] v_wdata;
  logic          v_done;
  logic [VW-1:0] v_rdata;
  logic          v_busy;

  logic [31:0]   mem_a;
  logic [31:0]   mem_wd;
  logic          mem_we;
  logic [31:0]   mem_rd1;
  logic [VW-1:0] mem_rd2;

  modport master (
    output s_req, s_we, s_addr, s_wdata, v_req, v_we, v_addr, v_wdata, mem_rd1, mem_rd2,
    input  s_gnt, s_rdata, v_done, v_rdata, v_busy, mem_a, mem_wd, mem_we
  );

  modport slave (
    input  s_req, s_we, s_addr, s_wdata, v_req, v_we, v_addr, v_wdata, mem_rd1, mem_rd2,
    output s_gnt, s_rdata, v_done, v_rdata, v_busy, mem_a, mem_wd, mem_we
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares the single-ported data memory between the scalar path and the vector unit,
// serialising vector stores into word bursts. DMEM_ARB_PERF_EN adds perf counters.
module dmem_port_arbiter #(
  parameter int unsigned VLEN_WORDS = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  dmem_port_arbiter_if.slave bus
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]        perf_s_stall,
  output logic [31:0]        perf_vst_cnt
`endif
);
  localparam int unsigned   CW       = $clog2(VLEN_WORDS);
  localparam logic [CW-1:0] LAST_IDX = CW'(VLEN_WORDS - 1);

  typedef enum logic {IDLE, VST} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [29:0]   base;
  logic [31:0]   wbuf [VLEN_WORDS];
  logic          last_vec;

  logic          s_win;
  logic          v_win;
  logic          burst_end;
  logic          s_gnt;
  logic          v_done;
  logic          v_busy;
  logic          mem_we;
  logic [31:0]   mem_a;
  logic [31:0]   mem_wd;
  logic          unused_addr_lsb;

  // Byte offsets never reach the memory: every access is word aligned.
  assign unused_addr_lsb = ^{bus.s_addr[1:0], bus.v_addr[1:0]};

  // Round-robin: on a tie the requester not granted last wins.
  assign s_win     = (state == IDLE) && bus.s_req && (!bus.v_req || last_vec);
  assign v_win     = (state == IDLE) && bus.v_req && !s_win;
  assign burst_end = (state == VST) && (cnt == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      base     <= '0;
      last_vec <= 1'b1;
      for (int unsigned k = 0; k < VLEN_WORDS; k++) wbuf[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (s_win) begin
            last_vec <= 1'b0;
          end else if (v_win) begin
            last_vec <= 1'b1;
            if (bus.v_we) begin
              state <= VST;
              cnt   <= CW'(1);
              base  <= bus.v_addr[31:2];
              for (int unsigned k = 0; k < VLEN_WORDS; k++) wbuf[k] <= bus.v_wdata[32*k +: 32];
            end
          end
        end
        default: begin
          if (burst_end) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      endcase
    end
  end

  // Memory port mux; everything is held at zero while reset is asserted.
  always_comb begin
    s_gnt  = 1'b0;
    v_done = 1'b0;
    v_busy = 1'b0;
    mem_we = 1'b0;
    mem_a  = '0;
    mem_wd = '0;
    if (rst_n) begin
      if (state == VST) begin
        mem_a  = {base + 30'(cnt), 2'b00};
        mem_wd = wbuf[cnt];
        mem_we = 1'b1;
        v_busy = 1'b1;
        v_done = (cnt == LAST_IDX);
      end else if (s_win) begin
        mem_a  = {bus.s_addr[31:2], 2'b00};
        mem_wd = bus.s_wdata;
        mem_we = bus.s_we;
        s_gnt  = 1'b1;
      end else if (v_win) begin
        mem_a = {bus.v_addr[31:2], 2'b00};
        if (bus.v_we) begin
          mem_wd = bus.v_wdata[31:0];
          mem_we = 1'b1;
        end else begin
          v_done = 1'b1;
        end
      end
    end
  end

  assign bus.s_gnt   = s_gnt;
  assign bus.v_done  = v_done;
  assign bus.v_busy  = v_busy;
  assign bus.mem_we  = mem_we;
  assign bus.mem_a   = mem_a;
  assign bus.mem_wd  = mem_wd;
  assign bus.s_rdata = bus.mem_rd1;
  assign bus.v_rdata = bus.mem_rd2;

`ifdef DMEM_ARB_PERF_EN
  // Saturating stall and completed-store counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_s_stall <= '0;
      perf_vst_cnt <= '0;
    end else begin
      if (bus.s_req && !s_gnt && (perf_s_stall != 32'hFFFF_FFFF))
        perf_s_stall <= perf_s_stall + 32'd1;
      if (burst_end && (perf_vst_cnt != 32'hFFFF_FFFF))
        perf_vst_cnt <= perf_vst_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: memory model, per-cycle reference model and directed scenarios.
module tb_dmem_port_arbiter;
  localparam int unsigned VW = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   vdone_cnt = 0;
  logic [31:0] mem [128];
  logic init_req = 1'b1;
  logic [511:0] rd2;
  logic [31:0] wlog [$];
  bit   log_en = 1'b0;

  dmem_port_arbiter_if #(.VLEN_WORDS(VW)) bus ();

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_s_stall;
  logic [31:0] perf_vst_cnt;
`endif

  dmem_port_arbiter #(.VLEN_WORDS(VW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef DMEM_ARB_PERF_EN
    ,
    .perf_s_stall (perf_s_stall),
    .perf_vst_cnt (perf_vst_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Data memory: combinational reads, writes commit at the clock edge.
  always_comb begin
    rd2 = '0;
    for (int k = 0; k < 16; k++) rd2[32*k +: 32] = mem[bus.mem_a[8:2] + 7'(k)];
  end
  assign bus.mem_rd1 = mem[bus.mem_a[8:2]];
  assign bus.mem_rd2 = rd2;

  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < 128; i++) mem[i] <= 32'h5000_0000 + 32'(i);
    end else if (bus.mem_we) begin
      mem[bus.mem_a[8:2]] <= bus.mem_wd;
    end
  end

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: pending burst writes kept as a queue of (address, data).
  typedef struct packed { logic [31:0] a; logic [31:0] d; } wr_t;
  wr_t bq [$];
  bit  m_last_vec = 1'b1;

  always @(negedge clk) begin
    logic e_sg, e_vd, e_vb, e_we, c_wd, c_sr, c_vr;
    logic [31:0] e_a, e_wd;
    logic [511:0] e_vr;
    e_sg = 0; e_vd = 0; e_vb = 0; e_we = 0; c_wd = 1; c_sr = 0; c_vr = 0;
    e_a = '0; e_wd = '0; e_vr = '0;
    if (bus.v_done) vdone_cnt++;
    if (log_en && bus.mem_we) wlog.push_back(bus.mem_a);
    if (cyc >= 1) begin
      if (!rst_n) begin
        bq.delete();
        m_last_vec = 1'b1;
      end else if (bq.size() > 0) begin
        e_we = 1; e_vb = 1;
        e_a  = bq[0].a;
        e_wd = bq[0].d;
        e_vd = (bq.size() == 1);
        void'(bq.pop_front());
      end else if (bus.s_req && (!bus.v_req || m_last_vec)) begin
        e_sg = 1; c_sr = 1;
        e_a  = bus.s_addr & 32'hFFFF_FFFC;
        e_wd = bus.s_wdata;
        e_we = bus.s_we;
        m_last_vec = 1'b0;
      end else if (bus.v_req) begin
        m_last_vec = 1'b1;
        e_a = bus.v_addr & 32'hFFFF_FFFC;
        if (bus.v_we) begin
          e_we = 1;
          e_wd = bus.v_wdata[31:0];
          for (int k = 1; k < 16; k++)
            bq.push_back('{a: e_a + 32'(4 * k), d: bus.v_wdata[32*k +: 32]});
        end else begin
          e_vd = 1; c_wd = 0; c_vr = 1;
          for (int k = 0; k < 16; k++) e_vr[32*k +: 32] = mem[e_a[8:2] + 7'(k)];
        end
      end
      chk("s_gnt", 512'(bus.s_gnt), 512'(e_sg));
      chk("v_done", 512'(bus.v_done), 512'(e_vd));
      chk("v_busy", 512'(bus.v_busy), 512'(e_vb));
      chk("mem_we", 512'(bus.mem_we), 512'(e_we));
      chk("mem_a", 512'(bus.mem_a[31:2]), 512'(e_a[31:2]));
      if (c_wd) chk("mem_wd", 512'(bus.mem_wd), 512'(e_wd));
      if (c_sr) chk("s_rdata", 512'(bus.s_rdata), 512'(mem[e_a[8:2]]));
      if (c_vr) chk("v_rdata", bus.v_rdata, e_vr);
    end
  end

  task automatic scalar_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                               output logic [31:0] rd, output int lat);
    int t0;
    bit got;
    t0 = cyc; got = 0; rd = '0; lat = -1;
    bus.s_req = 1'b1; bus.s_we = we; bus.s_addr = addr; bus.s_wdata = wd;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      if (bus.s_gnt) begin
        got = 1; rd = bus.s_rdata; lat = cyc - t0;
      end
      step();
    end
    bus.s_req = 1'b0; bus.s_we = 1'b0;
    chk("s_handshake", 512'(got), 512'(1));
  endtask

  task automatic vec_access(input logic we, input logic [31:0] addr, input logic [511:0] wd,
                            output logic [511:0] rd, output int t_gnt, output int t_done);
    int t0;
    t0 = cyc; t_gnt = -1; t_done = -1; rd = '0;
    bus.v_req = 1'b1; bus.v_we = we; bus.v_addr = addr; bus.v_wdata = wd;
    for (int n = 0; n < 100 && t_done < 0; n++) begin
      @(negedge clk);
      if (t_gnt < 0 && (bus.v_done || (bus.mem_we && !bus.s_gnt && !bus.v_busy))) t_gnt = cyc - t0;
      if (bus.v_done) begin
        t_done = cyc - t0; rd = bus.v_rdata;
      end
      step();
      // Store data is buffered at the grant, so the requester may scramble it afterwards.
      if (t_gnt >= 0 && t_done < 0) bus.v_wdata = {16{$urandom()}};
    end
    bus.v_req = 1'b0; bus.v_we = 1'b0;
    chk("v_handshake", 512'(t_done >= 0), 512'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] srd;
    logic [511:0] vd, vrd;
    logic [31:0] pre [16];
    int lat, tg, td, slat, vd0;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0] ps0, pv0;
`endif
    bus.s_req = 0; bus.s_we = 0; bus.s_addr = '0; bus.s_wdata = '0;
    bus.v_req = 0; bus.v_we = 0; bus.v_addr = '0; bus.v_wdata = '0;

    // Reset with both requesters active: outputs must stay quiet.
    step();
    init_req = 1'b0;
    bus.s_req = 1; bus.s_we = 1; bus.v_req = 1; bus.v_we = 1;
    @(negedge clk);
    chk("rst_s_gnt", 512'(bus.s_gnt), 512'(0));
    chk("rst_mem_we", 512'(bus.mem_we), 512'(0));
    chk("rst_v_done", 512'(bus.v_done), 512'(0));
    step();
    bus.s_req = 0; bus.s_we = 0; bus.v_req = 0; bus.v_we = 0;
    step();
    rst_n = 1'b1;
    step();

    // Scalar write then read back.
    scalar_access(1'b1, 32'h20, 32'hDEAD_BEEF, srd, lat);
    chk("s_wr_lat", 512'(lat), 512'(0));
    scalar_access(1'b0, 32'h20, 32'h0, srd, lat);
    chk("s_rd_lat", 512'(lat), 512'(0));
    chk("s_rd_data", 512'(srd), 512'(32'hDEAD_BEEF));

    // Unaligned byte address lands on word 8.
    scalar_access(1'b1, 32'h23, 32'h1234_5678, srd, lat);
    chk("align_w8", 512'(mem[8]), 512'(32'h1234_5678));
    chk("align_w9", 512'(mem[9]), 512'(32'h5000_0009));

    // Vector store of 0x100+k at 0x40, then vector load back.
    for (int k = 0; k < 16; k++) vd[32*k +: 32] = 32'h100 + 32'(k);
    wlog.delete();
    vd0 = vdone_cnt;
    log_en = 1'b1;
    vec_access(1'b1, 32'h40, vd, vrd, tg, td);
    log_en = 1'b0;
    chk("vst_gnt", 512'(tg), 512'(0));
    chk("vst_done_lat", 512'(td), 512'(15));
    chk("vst_done_cnt", 512'(vdone_cnt - vd0), 512'(1));
    chk("vst_nwrites", 512'(wlog.size()), 512'(16));
    for (int k = 0; k < 16 && k < wlog.size(); k++)
      chk("vst_addr", 512'(wlog[k]), 512'(32'h40 + 32'(4 * k)));
    vec_access(1'b0, 32'h40, '0, vrd, tg, td);
    chk("vld_lat", 512'(td), 512'(0));
    for (int k = 0; k < 16; k++) chk("vld_word", 512'(vrd[32*k +: 32]), 512'(32'h100 + 32'(k)));

    // Scalar read arriving at T+3 of a store is held off until T+16.
`ifdef DMEM_ARB_PERF_EN
    ps0 = perf_s_stall;
    pv0 = perf_vst_cnt;
`endif
    for (int k = 0; k < 16; k++) vd[32*k +: 32] = 32'hC00 + 32'(k);
    fork
      vec_access(1'b1, 32'h100, vd, vrd, tg, td);
      begin
        repeat (3) step();
        scalar_access(1'b0, 32'h20, 32'h0, srd, slat);
      end
    join
    chk("stall_vdone", 512'(td), 512'(15));
    chk("stall_lat", 512'(slat), 512'(13));
    chk("stall_rdata", 512'(srd), 512'(32'h1234_5678));
    chk("stall_w79", 512'(mem[79]), 512'(32'hC0F));
    step();
`ifdef DMEM_ARB_PERF_EN
    chk("perf_s_stall", 512'(perf_s_stall - ps0), 512'(13));
    chk("perf_vst_cnt", 512'(perf_vst_cnt - pv0), 512'(1));
`endif

    // Round-robin tie straight after reset: scalar first, then alternate.
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    bus.s_req = 1; bus.s_we = 0; bus.s_addr = 32'h20;
    bus.v_req = 1; bus.v_we = 0; bus.v_addr = 32'h40;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rr_s_gnt", 512'(bus.s_gnt), 512'(i % 2 == 0));
      chk("rr_v_done", 512'(bus.v_done), 512'(i % 2 == 1));
      step();
    end
    bus.s_req = 0; bus.v_req = 0;
    step();

    // Reset at T+5 of a store of 0xAA+k to base 0.
    for (int k = 0; k < 16; k++) pre[k] = mem[k];
    for (int k = 0; k < 16; k++) vd[32*k +: 32] = 32'hAA + 32'(k);
    vd0 = vdone_cnt;
    bus.v_req = 1; bus.v_we = 1; bus.v_addr = 32'h0; bus.v_wdata = vd;
    repeat (5) step();
    rst_n = 1'b0;
    bus.v_req = 0; bus.v_we = 0;
    repeat (2) step();
    rst_n = 1'b1;
    scalar_access(1'b0, 32'h10, 32'h0, srd, lat);
    chk("mid_rst_idle_lat", 512'(lat), 512'(0));
    chk("mid_rst_rd_w4", 512'(srd), 512'(32'hAE));
    chk("mid_rst_no_done", 512'(vdone_cnt - vd0), 512'(0));
    for (int k = 0; k < 16; k++)
      chk("mid_rst_mem", 512'(mem[k]), 512'(k < 5 ? 32'hAA + 32'(k) : pre[k]));
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
